// File: rtl/gpu_pkg.sv
// Shared definitions for the line-command queue: rasterizer/queue register
// indices, the 37-bit command layout and the engine state encoding.
package gpu_pkg;

  localparam logic [2:0] RA_X0    = 3'd0;
  localparam logic [2:0] RA_Y0    = 3'd1;
  localparam logic [2:0] RA_X1    = 3'd2;
  localparam logic [2:0] RA_Y1    = 3'd3;
  localparam logic [2:0] RA_COLOR = 3'd4;
  localparam logic [2:0] RA_START = 3'd5;
  localparam logic [2:0] RA_BUSY  = 3'd6;

  localparam logic [3:0] Q_CMD_A   = 4'd0;
  localparam logic [3:0] Q_CMD_B   = 4'd1;
  localparam logic [3:0] Q_STATUS  = 4'd2;
  localparam logic [3:0] Q_OVF     = 4'd3;
  localparam logic [3:0] Q_DONE    = 4'd4;
  localparam logic [3:0] Q_IRQ_CLR = 4'd5;

  localparam int CMD_W = 37;

  typedef struct packed {
    logic       colour;
    logic [8:0] y1;
    logic [8:0] x1;
    logic [8:0] y0;
    logic [8:0] x0;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_POLL_S = 3'd2,
    ST_POLL_B = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  function automatic logic [31:0] raster_wdata(input cmd_t c, input logic [2:0] idx);
    case (idx)
      RA_X0:    raster_wdata = {23'd0, c.x0};
      RA_Y0:    raster_wdata = {23'd0, c.y0};
      RA_X1:    raster_wdata = {23'd0, c.x1};
      RA_Y1:    raster_wdata = {23'd0, c.y1};
      RA_COLOR: raster_wdata = {31'd0, c.colour};
      RA_START: raster_wdata = 32'd1;
      default:  raster_wdata = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/gpu_cmdq_fifo.sv
// Synchronous FIFO; a push while full is taken only if a pop happens on the
// same edge.
module gpu_cmdq_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s, do_pop_s;

  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmdq_wb.sv
// Wishbone line-command queue feeding the rasterizer. Optional queue-drained
// interrupt is built when GPU_CMDQ_IRQ_EN is defined.
module gpu_cmdq_wb
  import gpu_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] RASTER_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
`ifdef GPU_CMDQ_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          slv_req_s, slv_wr_s, push_s, pop_s, irq_s;
  logic [3:0]    slv_idx_s;
  logic [8:0]    x0_r, y0_r, x1_r, y1_r;
  logic          colour_r, ovf_r;
  logic [15:0]   done_cnt_r;
  logic [31:0]   rd_data_s, status_s;
  cmd_t          push_cmd_s, fifo_dout_s, cmd_r, cmd_nxt_s;
  logic          full_s, empty_s;
  logic [CW-1:0] count_s;
  state_t        state_r, state_nxt_s;
  logic [2:0]    idx_r, idx_nxt_s;
  logic          gap_r, gap_nxt_s;
  logic          cyc_nxt_s, stb_nxt_s, we_nxt_s;
  logic [31:0]   adr_nxt_s, dat_nxt_s;
  logic          unused_ok_s;

  assign unused_ok_s = &{1'b0, wb_sel_i, wb_adr_i[31:4], m_dat_i[31:1]};
  // Blocking the request while ack is high prevents back-to-back acks.
  assign slv_req_s = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign slv_wr_s  = slv_req_s & wb_we_i;
  assign slv_idx_s = wb_adr_i[3:0];
  assign push_s    = slv_wr_s & (slv_idx_s == Q_CMD_B);
  assign pop_s     = (state_r == ST_IDLE) & ~empty_s;

  // New entry combines the CMD_A staging register with the incoming CMD_B word.
  always_comb begin
    push_cmd_s        = '0;
    push_cmd_s.x0     = x0_r;
    push_cmd_s.y0     = y0_r;
    push_cmd_s.x1     = wb_dat_i[8:0];
    push_cmd_s.y1     = wb_dat_i[24:16];
    push_cmd_s.colour = wb_dat_i[31];
  end

  gpu_cmdq_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_cmd_s),
    .dout  (fifo_dout_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Staging registers and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_r <= 9'd0; y0_r <= 9'd0; x1_r <= 9'd0; y1_r <= 9'd0;
      colour_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (slv_wr_s) begin
      case (slv_idx_s)
        Q_CMD_A: begin
          x0_r <= wb_dat_i[8:0];
          y0_r <= wb_dat_i[24:16];
        end
        Q_CMD_B: begin
          x1_r     <= wb_dat_i[8:0];
          y1_r     <= wb_dat_i[24:16];
          colour_r <= wb_dat_i[31];
          if (full_s && !pop_s) ovf_r <= 1'b1;
        end
        Q_OVF:   ovf_r <= 1'b0;
        default: ovf_r <= ovf_r;
      endcase
    end
  end

`ifdef GPU_CMDQ_IRQ_EN
  // Queue-drained interrupt: set on completion with nothing left, cleared by IRQ_CLR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_o <= 1'b0;
    else if (state_r == ST_FIN && empty_s) irq_o <= 1'b1;
    else if (slv_wr_s && slv_idx_s == Q_IRQ_CLR) irq_o <= 1'b0;
  end
  assign irq_s = irq_o;
`else
  assign irq_s = 1'b0;
`endif

  // Slave read mux.
  always_comb begin
    status_s       = 32'd0;
    status_s[0]    = empty_s;
    status_s[1]    = full_s;
    status_s[2]    = (state_r != ST_IDLE);
    status_s[3]    = irq_s;
    status_s[14:8] = 7'(count_s);
    case (slv_idx_s)
      Q_CMD_A:  rd_data_s = {7'd0, y0_r, 7'd0, x0_r};
      Q_CMD_B:  rd_data_s = {colour_r, 6'd0, y1_r, 7'd0, x1_r};
      Q_STATUS: rd_data_s = status_s;
      Q_OVF:    rd_data_s = {31'd0, ovf_r};
      Q_DONE:   rd_data_s = {16'd0, done_cnt_r};
      default:  rd_data_s = 32'd0;
    endcase
  end

  // Slave ack pulse and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      wb_ack_o <= slv_req_s;
      wb_dat_o <= (slv_req_s && !wb_we_i) ? rd_data_s : 32'd0;
    end
  end

  // Engine state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd0;
      gap_r   <= 1'b0;
      cmd_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      gap_r   <= gap_nxt_s;
      cmd_r   <= cmd_nxt_s;
    end
  end

  // Engine next state; gap_r marks the one idle-strobe cycle after each ack.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    gap_nxt_s   = gap_r;
    cmd_nxt_s   = cmd_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_nxt_s = ST_WR;
          idx_nxt_s   = RA_X0;
          gap_nxt_s   = 1'b0;
          cmd_nxt_s   = fifo_dout_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR: begin
        if (gap_r) begin
          gap_nxt_s = 1'b0;
        end else if (m_ack_i) begin
          gap_nxt_s = 1'b1;
          if (idx_r == RA_START) state_nxt_s = ST_POLL_S;
          else idx_nxt_s = idx_r + 3'd1;
        end else begin
          gap_nxt_s = 1'b0;
        end
      end
      ST_POLL_S: begin
        if (gap_r) begin
          gap_nxt_s = 1'b0;
        end else if (m_ack_i) begin
          gap_nxt_s = 1'b1;
          if (!m_dat_i[0]) begin
            state_nxt_s = ST_POLL_B;
            idx_nxt_s   = RA_BUSY;
          end else begin
            state_nxt_s = ST_POLL_S;
          end
        end else begin
          gap_nxt_s = 1'b0;
        end
      end
      ST_POLL_B: begin
        if (gap_r) begin
          gap_nxt_s = 1'b0;
        end else if (m_ack_i) begin
          gap_nxt_s = 1'b1;
          if (!m_dat_i[0]) state_nxt_s = ST_FIN;
          else state_nxt_s = ST_POLL_B;
        end else begin
          gap_nxt_s = 1'b0;
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
        gap_nxt_s   = 1'b0;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Master bus values decoded from the next state so the outputs are registered.
  always_comb begin
    cyc_nxt_s = (state_nxt_s == ST_WR) || (state_nxt_s == ST_POLL_S) ||
                (state_nxt_s == ST_POLL_B);
    stb_nxt_s = cyc_nxt_s & ~gap_nxt_s;
    we_nxt_s  = stb_nxt_s & (state_nxt_s == ST_WR);
    if (stb_nxt_s) adr_nxt_s = RASTER_BASE | {29'd0, idx_nxt_s};
    else adr_nxt_s = 32'd0;
    if (we_nxt_s) dat_nxt_s = raster_wdata(cmd_nxt_s, idx_nxt_s);
    else dat_nxt_s = 32'd0;
  end

  // Master output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc_o <= 1'b0; m_stb_o <= 1'b0; m_we_o <= 1'b0;
      m_sel_o <= 4'd0; m_adr_o <= 32'd0; m_dat_o <= 32'd0;
    end else begin
      m_cyc_o <= cyc_nxt_s;
      m_stb_o <= stb_nxt_s;
      m_we_o  <= we_nxt_s;
      m_sel_o <= {4{stb_nxt_s}};
      m_adr_o <= adr_nxt_s;
      m_dat_o <= dat_nxt_s;
    end
  end

  // Completed-command counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_cnt_r <= 16'd0;
    else if (state_r == ST_FIN) done_cnt_r <= done_cnt_r + 16'd1;
  end

endmodule
